// File: rtl/demux8_stream.sv
// Registered 1-to-8 stream demux with a one-entry slot per channel.
// Optional DEMUX_BROADCAST_EN adds in_bcast to load all eight slots at once.
module demux8_stream #(
    parameter int width = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width-1:0]   in_data,
    input  logic [2:0]         in_sel,
`ifdef DEMUX_BROADCAST_EN
    input  logic               in_bcast,
`endif
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [8*width-1:0] out_data,
    output logic               busy
);

    logic [7:0]       open_slot;
    logic [7:0]       target;
    logic [7:0]       load;
    logic [width-1:0] slot_data [8];

    always_comb begin
        open_slot        = ~out_valid | out_ready;
        target           = 8'd0;
        target[in_sel]   = 1'b1;
        in_ready         = open_slot[in_sel];
`ifdef DEMUX_BROADCAST_EN
        if (in_bcast) begin
            target   = 8'hFF;
            in_ready = &open_slot;
        end
`endif
        load = target & {8{in_valid & in_ready}};
    end

    // A slot refilled in the same cycle it drains stays full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 8'd0;
            for (int k = 0; k < 8; k++) slot_data[k] <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (load[k]) begin
                    out_valid[k] <= 1'b1;
                    slot_data[k] <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 8; k++) out_data[k*width +: width] = slot_data[k];
    end

    assign busy = |out_valid;

endmodule

// File: tb/tb_demux8_stream.sv
// Directed and scoreboarded checks for demux8_stream.
module tb_demux8_stream;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [2:0]     in_sel;
`ifdef DEMUX_BROADCAST_EN
    logic           in_bcast;
`endif
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [8*W-1:0] out_data;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q [8][$];

    demux8_stream #(.width(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_sel(in_sel),
`ifdef DEMUX_BROADCAST_EN
        .in_bcast(in_bcast),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] lane(input int k);
        return out_data[k*W +: W];
    endfunction

    initial begin
        int cyc;
        int bad;
        logic exp_rdy;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd1;
        in_data   = 32'h1234;
        out_ready = 8'h00;
`ifdef DEMUX_BROADCAST_EN
        in_bcast  = 1'b0;
`endif
        #2;
        chk("rst_valid", 256'(out_valid), 256'h0);
        chk("rst_busy", 256'(busy), 256'h0);
        chk("rst_data", 256'(out_data), 256'h0);
        step();
        chk("rst_no_accept", 256'(out_valid), 256'h0);
        rst_n = 1'b1;

        // unicast to channel 5
        in_sel    = 3'd5;
        in_data   = 32'hDEADBEEF;
        out_ready = 8'hFF;
        #1;
        chk("uni_ready", 256'(in_ready), 256'h1);
        step();
        in_valid = 1'b0;
        chk("uni_valid", 256'(out_valid), 256'h20);
        chk("uni_data", 256'(lane(5)), 256'hDEADBEEF);
        chk("uni_busy", 256'(busy), 256'h1);
        step();
        chk("uni_drain", 256'(out_valid), 256'h0);
        chk("uni_hold", 256'(lane(5)), 256'hDEADBEEF);

        // backpressure isolation
        out_ready = 8'hFB;
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 32'h22;
        step();
        chk("bp_fill", 256'(out_valid), 256'h04);
        in_valid = 1'b0;
        #1;
        chk("bp_rdy_novalid", 256'(in_ready), 256'h0);
        in_valid = 1'b1;
        in_data  = 32'h99;
        #1;
        chk("bp_rdy_sel2", 256'(in_ready), 256'h0);
        step();
        chk("bp_blocked_v", 256'(out_valid), 256'h04);
        chk("bp_blocked_d", 256'(lane(2)), 256'h22);
        in_sel  = 3'd6;
        in_data = 32'h66;
        #1;
        chk("bp_rdy_sel6", 256'(in_ready), 256'h1);
        step();
        in_valid = 1'b0;
        chk("bp_ch6_v", 256'(out_valid), 256'h44);
        chk("bp_ch6_d", 256'(lane(6)), 256'h66);
        step();
        chk("bp_ch6_drain", 256'(out_valid), 256'h04);
        chk("bp_ch2_stable", 256'(lane(2)), 256'h22);
        out_ready = 8'hFF;
        step();
        chk("bp_ch2_drain", 256'(out_valid), 256'h00);

        // same-cycle drain and refill
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        in_data   = 32'h1;
        step();
        chk("dr_fill", 256'(lane(0)), 256'h1);
        out_ready = 8'hFF;
        in_data   = 32'h2;
        #1;
        chk("dr_ready", 256'(in_ready), 256'h1);
        step();
        chk("dr_valid", 256'(out_valid), 256'h01);
        chk("dr_data", 256'(lane(0)), 256'h2);

        // 100-word stream into channel 0
        cyc = 0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            in_data = 32'(i + 1000);
            #1;
            if (in_ready !== 1'b1) bad++;
            step();
            cyc++;
            if (out_valid !== 8'h01 || lane(0) !== 32'(i + 1000)) bad++;
        end
        in_valid = 1'b0;
        while (out_valid[0] === 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("stream_bad", 256'(bad), 256'h0);
        chk("stream_cycles", 256'(cyc), 256'd101);

        // async reset with slot 3 full
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_sel    = 3'd3;
        in_data   = 32'h33;
        step();
        in_valid = 1'b0;
        chk("ar_full", 256'(out_valid), 256'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 256'(out_valid), 256'h0);
        chk("ar_data", 256'(out_data), 256'h0);
        chk("ar_busy", 256'(busy), 256'h0);
        step();
        rst_n = 1'b1;

        // random soak with per-channel scoreboard
        for (int c = 0; c < 3000; c++) begin
            step();
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = $urandom;
            out_ready = 8'($urandom);
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                chk("soak_valid", 256'(out_valid[k]), 256'(q[k].size() != 0));
                if (q[k].size() != 0)
                    chk("soak_data", 256'(lane(k)), 256'(q[k][0]));
            end
            exp_rdy = (q[in_sel].size() == 0) || out_ready[in_sel];
            chk("soak_ready", 256'(in_ready), 256'(exp_rdy));
            for (int k = 0; k < 8; k++)
                if (out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
            if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 8'hFF;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("flush_valid", 256'(out_valid[k]), 256'(q[k].size() != 0));
            if (q[k].size() != 0) begin
                chk("flush_data", 256'(lane(k)), 256'(q[k][0]));
                void'(q[k].pop_front());
            end
        end
        step();
        chk("soak_empty", 256'(out_valid), 256'h0);

`ifdef DEMUX_BROADCAST_EN
        out_ready = 8'hEF;
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        in_data   = 32'h44;
        step();
        chk("bc_fill4", 256'(out_valid), 256'h10);
        in_bcast = 1'b1;
        in_sel   = 3'd1;
        in_data  = 32'hA5A5A5A5;
        #1;
        chk("bc_blocked", 256'(in_ready), 256'h0);
        step();
        chk("bc_hold", 256'(out_valid), 256'h10);
        chk("bc_hold_d", 256'(lane(4)), 256'h44);
        out_ready = 8'hFF;
        #1;
        chk("bc_ready", 256'(in_ready), 256'h1);
        step();
        in_valid  = 1'b0;
        in_bcast  = 1'b0;
        out_ready = 8'h00;
        chk("bc_valid", 256'(out_valid), 256'hFF);
        chk("bc_data", 256'(out_data), {8{32'hA5A5A5A5}});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
